// File: rtl/npu_wb_pkg.sv
// npu_wb_pkg: register map, STATUS/CTRL bit positions and default window base for the NPU Wishbone bridge
package npu_wb_pkg;
  localparam logic [31:0] DEFAULT_BASE_ADR = 32'h3000_0000;
  localparam logic [3:0] REG_CMD    = 4'h0;
  localparam logic [3:0] REG_RSP    = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_CTRL   = 4'hC;
  localparam int STS_CMD_FULL  = 0;
  localparam int STS_CMD_EMPTY = 1;
  localparam int STS_RSP_FULL  = 2;
  localparam int STS_RSP_EMPTY = 3;
  localparam int STS_CMD_CNT   = 4;
  localparam int STS_RSP_CNT   = 9;
  localparam int STS_OVERFLOW  = 16;
  localparam int STS_UNDERFLOW = 17;
  localparam int CTRL_IRQ_EN   = 0;
  localparam int CTRL_FLUSH    = 1;
endpackage

// File: rtl/npu_wb_cmd_bridge_fifo.sv
// npu_sync_fifo: single-clock FIFO with flush and occupancy count
// Ports: clk/rst (sync, active-high), flush, push/din, pop/dout, full, empty, count.
// dout reads 0 while empty so downstream data buses idle at zero.
module npu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // flush shares the reset path so it overrides any push or pop in the same cycle
  always_ff @(posedge clk)
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/npu_wb_cmd_bridge.sv
// npu_wb_cmd_bridge: Wishbone slave turning CMD writes into an NPU command stream and buffering NPU results
// Ports: wb_clk_i/wb_rst_i; wbs_* classic Wishbone slave; cmd_valid_o/cmd_data_o/cmd_ready_i
// command stream out; rsp_valid_i/rsp_data_i/rsp_ready_o result stream in; irq_o level IRQ.
module npu_wb_cmd_bridge import npu_wb_pkg::*; #(
  parameter logic [31:0] BASE_ADR  = DEFAULT_BASE_ADR,
  parameter int          CMD_DEPTH = 8,
  parameter int          RSP_DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cmd_valid_o,
  output logic [31:0] cmd_data_o,
  input  logic        cmd_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        rsp_ready_o,
  output logic        irq_o
);
  logic [$clog2(CMD_DEPTH):0] cmd_count;
  logic [$clog2(RSP_DEPTH):0] rsp_count;
  logic [31:0] rsp_head, status, rdata;
  logic [3:0] off;
  logic req, wr, rd, cmd_push, rsp_pop, flush;
  logic cmd_full, cmd_empty, rsp_full, rsp_empty;
  logic irq_en, overflow, underflow;
  // ~ack keeps a held strobe from being served twice back to back
  assign req      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]) & ~wbs_ack_o;
  assign off      = wbs_adr_i[3:0] & 4'hC;
  assign wr       = req & wbs_we_i;
  assign rd       = req & ~wbs_we_i;
  assign cmd_push = wr & (off == REG_CMD) & (wbs_sel_i == 4'hF);
  assign rsp_pop  = rd & (off == REG_RSP);
  assign flush    = wr & (off == REG_CTRL) & wbs_dat_i[CTRL_FLUSH];
  assign cmd_valid_o = ~cmd_empty;
  assign rsp_ready_o = ~rsp_full;
  always_comb begin
    status = '0;
    status[STS_CMD_FULL]         = cmd_full;
    status[STS_CMD_EMPTY]        = cmd_empty;
    status[STS_RSP_FULL]         = rsp_full;
    status[STS_RSP_EMPTY]        = rsp_empty;
    status[STS_CMD_CNT +: 5]     = 5'(cmd_count);
    status[STS_RSP_CNT +: 5]     = 5'(rsp_count);
    status[STS_OVERFLOW]         = overflow;
    status[STS_UNDERFLOW]        = underflow;
    rdata = off == REG_RSP    ? rsp_head :
            off == REG_STATUS ? status :
            off == REG_CTRL   ? {31'd0, irq_en} : '0;
  end
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : '0;
      irq_o     <= irq_en & ~rsp_empty;
      if (wr && off == REG_STATUS) begin
        if (wbs_dat_i[STS_OVERFLOW])  overflow  <= 1'b0;
        if (wbs_dat_i[STS_UNDERFLOW]) underflow <= 1'b0;
      end
      if (cmd_push && cmd_full) overflow <= 1'b1;
      if (rsp_pop && rsp_empty) underflow <= 1'b1;
      if (wr && off == REG_CTRL) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
    end
  npu_sync_fifo #(.WIDTH(32), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk(wb_clk_i), .rst(wb_rst_i), .flush(flush),
    .push(cmd_push), .din(wbs_dat_i), .pop(cmd_ready_i), .dout(cmd_data_o),
    .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
  );
  npu_sync_fifo #(.WIDTH(32), .DEPTH(RSP_DEPTH)) u_rsp (
    .clk(wb_clk_i), .rst(wb_rst_i), .flush(flush),
    .push(rsp_valid_i), .din(rsp_data_i), .pop(rsp_pop), .dout(rsp_head),
    .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
  );
endmodule
